// File: rtl/armleocpu_multiplier_param.sv
// ---------------------------------------------------------------------------
// armleocpu_multiplier_param
//
// Iterative shift-add multiplier that produces the full 2*WIDTH-bit product.
// Supports unsigned, signed and signed-by-unsigned operands, which cover the
// sources of RISC-V MUL/MULH/MULHSU/MULHU. The execute stage picks the half of
// the result that it needs. The unit multiplies magnitudes and fixes the sign
// at the end. The smaller magnitude drives the iteration, so a short operand
// finishes early.
//
// Parameters:
//   WIDTH          operand width; >= 4 and a multiple of BITS_PER_CYCLE
//   BITS_PER_CYCLE multiplier bits consumed per OP cycle (1, 2 or 4)
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   valid_i    request, sampled only while idle
//   kill_i     abort in-flight operation (also blocks an accept while idle)
//   mode_i     00 u*u, 01 s*s, 10 s(f0)*u(f1), 11 same as 00
//   factor0_i  operand 0
//   factor1_i  operand 1
//   busy_o     high while an operation is in flight (OP or FINISH)
//   ready_o    one-cycle completion pulse
//   result_o   registered product, held until the next completion
// ---------------------------------------------------------------------------
module armleocpu_multiplier_param #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic                 kill_i,
  input  logic [1:0]           mode_i,
  input  logic [WIDTH-1:0]     factor0_i,
  input  logic [WIDTH-1:0]     factor1_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OP     = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     acc_q;
  logic [PW-1:0]     a_q;
  logic [WIDTH-1:0]  b_q;
  logic [CNT_W-1:0]  count_q;
  logic              neg_q;
  logic              ready_q;
  logic [PW-1:0]     result_q;

  // Operand conditioning: signs, magnitudes and larger/smaller ordering.
  logic              sign0_c;
  logic              sign1_c;
  logic [WIDTH-1:0]  mag0_c;
  logic [WIDTH-1:0]  mag1_c;
  logic [WIDTH-1:0]  big_c;
  logic [WIDTH-1:0]  small_c;

  always_comb begin
    sign0_c = ((mode_i == 2'b01) || (mode_i == 2'b10)) && factor0_i[WIDTH-1];
    sign1_c = (mode_i == 2'b01) && factor1_i[WIDTH-1];
    // Negating the most-negative value wraps to 2^(WIDTH-1), which is the
    // correct unsigned magnitude.
    mag0_c  = sign0_c ? (~factor0_i + WIDTH'(1)) : factor0_i;
    mag1_c  = sign1_c ? (~factor1_i + WIDTH'(1)) : factor1_i;
    // Tie goes to a = |f1|.
    if (mag0_c > mag1_c) begin
      big_c   = mag0_c;
      small_c = mag1_c;
    end else begin
      big_c   = mag1_c;
      small_c = mag0_c;
    end
  end

  // One iteration step plus the final sign fix-up.
  logic [BITS_PER_CYCLE-1:0] digit_d;
  logic [PW-1:0]             acc_d;
  logic [PW-1:0]             a_d;
  logic [WIDTH-1:0]          b_d;
  logic [PW-1:0]             prod_d;

  always_comb begin
    digit_d = b_q[BITS_PER_CYCLE-1:0];
    // The digit is at most 4 bits, so this is a short add tree, not a full
    // multiplier.
    acc_d   = acc_q + (a_q * PW'(digit_d));
    a_d     = a_q << BITS_PER_CYCLE;
    b_d     = b_q >> BITS_PER_CYCLE;
    prod_d  = neg_q ? (~acc_q + PW'(1)) : acc_q;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_i && !kill_i) begin
            a_q     <= PW'(big_c);
            b_q     <= small_c;
            neg_q   <= sign0_c ^ sign1_c;
            acc_q   <= '0;
            count_q <= '0;
            state_q <= S_OP;
          end
        end
        S_OP: begin
          if (kill_i) begin
            state_q <= S_IDLE;
          end else if (b_q == '0) begin
            // Early termination: no set bits remain in the smaller operand.
            state_q <= S_FINISH;
          end else begin
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            if (count_q == LAST_CNT) begin
              state_q <= S_FINISH;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          if (!kill_i) begin
            result_q <= prod_d;
            ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule
